// File: rtl/apb_reg_slave_if.sv
// APB3 bus bundle between a requester and the apb_reg_slave completer.
interface apb_reg_slave_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_reg_slave.sv
// APB3 completer: seven read/write registers plus a read-only counter of
// error-free transfers, with a fixed number of wait states per transfer.
module apb_reg_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic            clk,
  input logic            rst,
  apb_reg_slave_if.slave bus
);

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wcnt;
  logic [2:0]  lat_idx;
  logic        lat_write;
  logic [31:0] lat_wdata;
  logic        lat_err;
  logic [31:0] regs [0:6];
  logic [31:0] cnt;

  logic [11:0] offset;
  logic        decode_err;
  logic        setup;
  logic        at_limit;
  logic        commit;
  logic [31:0] rdata_mux;

  // Address decode of the live bus, only consumed on the setup edge.
  always_comb begin
    offset     = bus.paddr[11:0];
    decode_err = (bus.paddr[31:12] != BASE_ADDR[31:12])
               | (bus.paddr[1:0] != 2'b00)
               | (offset > 12'h01C)
               | (bus.pwrite & (offset == 12'h01C));
  end

  assign setup    = (state == IDLE) & bus.psel & ~bus.penable;
  assign at_limit = (state == ACCESS) & (wcnt == WAIT_LIM);
  // A transfer whose psel vanished is an abort, even on its final cycle.
  assign commit   = at_limit & bus.psel & ~lat_err;

  // Next-state logic: leave ACCESS on completion or on master abort.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (setup) state_next = ACCESS;
      ACCESS:  if (!bus.psel || at_limit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture the setup-phase request and count wait states during ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= 4'd0;
      lat_idx   <= 3'd0;
      lat_write <= 1'b0;
      lat_wdata <= 32'd0;
      lat_err   <= 1'b0;
    end else if (setup) begin
      wcnt      <= 4'd0;
      lat_idx   <= bus.paddr[4:2];
      lat_write <= bus.pwrite;
      lat_wdata <= bus.pwdata;
      lat_err   <= decode_err;
    end else if ((state == ACCESS) && !at_limit) begin
      wcnt      <= wcnt + 4'd1;
    end
  end

  // Register file and transfer counter update on the completing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) regs[i] <= 32'd0;
      cnt <= 32'd0;
    end else if (commit) begin
      for (int i = 0; i < 7; i++) begin
        if (lat_write && (lat_idx == 3'(i))) regs[i] <= lat_wdata;
      end
      cnt <= cnt + 32'd1;
    end
  end

  // Read mux; index 7 is the counter, which shows its pre-transfer value.
  always_comb begin
    rdata_mux = cnt;
    for (int i = 0; i < 7; i++) begin
      if (lat_idx == 3'(i)) rdata_mux = regs[i];
    end
  end

  assign bus.pready  = at_limit;
  assign bus.pslverr = at_limit & lat_err;
  assign bus.prdata  = (at_limit & ~lat_write & ~lat_err) ? rdata_mux : 32'd0;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: one instance with no wait states and
// one with three, driven by directed transfers with hand-computed results.
module tb_apb_reg_slave;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pslverr;
    logic [15:0] id;
  } exp_t;

  logic clk;
  logic rst0;
  logic rst3;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q0 [$];
  exp_t q3 [$];
  logic prev0 = 1'b0;
  logic prev3 = 1'b0;

  logic        b2b_wr   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] b2b_addr [7] = '{32'h1000_0000, 32'h1000_0018, 32'h1000_0000,
                                32'h1000_0018, 32'h1000_000C, 32'h1000_001C,
                                32'h1000_000C};
  logic [31:0] b2b_data [7] = '{32'h1111_1111, 32'h6666_6666, 32'h0, 32'h0,
                                32'hA5A5_5A5A, 32'h0, 32'h0};
  logic [31:0] b2b_exp  [7] = '{32'h0, 32'h0, 32'h1111_1111, 32'h6666_6666,
                                32'h0, 32'd5, 32'hA5A5_5A5A};
  int          starts   [7];

  apb_reg_slave_if bus0 ();
  apb_reg_slave_if bus3 ();

  apb_reg_slave #(.BASE_ADDR(32'h1000_0000), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0)
  );

  apb_reg_slave #(.BASE_ADDR(32'h1000_0000), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .bus(bus3)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure transfer spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic drive(input int which, input logic s, input logic en,
                       input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (which == 0) begin
      bus0.psel = s; bus0.penable = en; bus0.pwrite = wr;
      bus0.paddr = a; bus0.pwdata = d;
    end else begin
      bus3.psel = s; bus3.penable = en; bus3.pwrite = wr;
      bus3.paddr = a; bus3.pwdata = d;
    end
  endtask

  function automatic logic ready_of(input int which);
    return (which == 0) ? bus0.pready : bus3.pready;
  endfunction

  task automatic idle(input int which, input int n);
    drive(which, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One complete transfer; mangle perturbs paddr/pwdata during ACCESS.
  task automatic apply_stimulus(input int which, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input logic mangle, input int id);
    exp_t e;
    int   waits;
    e.prdata  = exp_rdata;
    e.pslverr = exp_err;
    e.id      = 16'(id);
    if (which == 0) q0.push_back(e);
    else            q3.push_back(e);
    drive(which, 1'b1, 1'b0, wr, addr, wdata);
    @(posedge clk); #1;
    if (mangle) drive(which, 1'b1, 1'b1, wr, addr ^ 32'h4, 32'hBAD0_BAD0);
    else        drive(which, 1'b1, 1'b1, wr, addr, wdata);
    waits = 0;
    while (!ready_of(which) && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    check_output($sformatf("xfer %0d wait states", id), 32'(waits),
                 (which == 0) ? 32'd0 : 32'd3);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor for the zero-wait instance.
  always @(negedge clk) begin
    exp_t e;
    if (bus0.pready === 1'b1) begin
      check_output("dut0 pready width", {31'b0, prev0}, 32'd0);
      if (q0.size() == 0) begin
        check_output("dut0 unexpected pready", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        check_output($sformatf("xfer %0d prdata", e.id), bus0.prdata, e.prdata);
        check_output($sformatf("xfer %0d pslverr", e.id), {31'b0, bus0.pslverr},
                     {31'b0, e.pslverr});
      end
    end else if (!rst0) begin
      check_output("dut0 quiet outputs", {bus0.prdata[30:0], bus0.pslverr},
                   32'd0);
    end
    prev0 = bus0.pready;
  end

  // Scoreboard monitor for the three-wait instance.
  always @(negedge clk) begin
    exp_t e;
    if (bus3.pready === 1'b1) begin
      check_output("dut3 pready width", {31'b0, prev3}, 32'd0);
      if (q3.size() == 0) begin
        check_output("dut3 unexpected pready", 32'd1, 32'd0);
      end else begin
        e = q3.pop_front();
        check_output($sformatf("xfer %0d prdata", e.id), bus3.prdata, e.prdata);
        check_output($sformatf("xfer %0d pslverr", e.id), {31'b0, bus3.pslverr},
                     {31'b0, e.pslverr});
      end
    end else if (!rst3) begin
      check_output("dut3 quiet outputs", {bus3.prdata[30:0], bus3.pslverr},
                   32'd0);
    end
    prev3 = bus3.pready;
  end

  // Directed sequence.
  initial begin
    rst0 = 1'b1;
    rst3 = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(3, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst3 = 1'b0;

    check_output("dut0 reset pready", {31'b0, bus0.pready}, 32'd0);
    check_output("dut0 reset pslverr", {31'b0, bus0.pslverr}, 32'd0);
    check_output("dut0 reset prdata", bus0.prdata, 32'd0);
    check_output("dut3 reset pready", {31'b0, bus3.pready}, 32'd0);
    check_output("dut3 reset pslverr", {31'b0, bus3.pslverr}, 32'd0);
    check_output("dut3 reset prdata", bus3.prdata, 32'd0);

    // penable without a setup phase must be ignored.
    drive(0, 1'b0, 1'b1, 1'b1, 32'h1000_0008, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check_output("penable alone pready", {31'b0, bus0.pready}, 32'd0);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h1000_0008, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check_output("psel+penable no setup pready", {31'b0, bus0.pready}, 32'd0);
    idle(0, 1);

    apply_stimulus(0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1);
    apply_stimulus(0, 1'b0, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2);
    idle(0, 1);
    apply_stimulus(0, 1'b0, 32'h1000_0008, 32'h0, 32'h0, 1'b0, 1'b0, 3);
    apply_stimulus(0, 1'b1, 32'h1000_001C, 32'h55, 32'h0, 1'b1, 1'b0, 4);
    apply_stimulus(0, 1'b0, 32'h1000_0020, 32'h0, 32'h0, 1'b1, 1'b0, 5);
    apply_stimulus(0, 1'b1, 32'h1000_0006, 32'h1234, 32'h0, 1'b1, 1'b0, 6);
    apply_stimulus(0, 1'b0, 32'h2000_0000, 32'h0, 32'h0, 1'b1, 1'b0, 7);
    apply_stimulus(0, 1'b0, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 8);
    apply_stimulus(0, 1'b0, 32'h1000_001C, 32'h0, 32'd4, 1'b0, 1'b0, 9);
    idle(0, 2);

    // Fresh start, then back-to-back transfers with no idle cycles.
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      starts[k] = cyc;
      apply_stimulus(0, b2b_wr[k], b2b_addr[k], b2b_data[k], b2b_exp[k], 1'b0,
                     1'b0, 10 + k);
    end
    for (int k = 1; k < 7; k++) begin
      check_output($sformatf("b2b spacing %0d", k), 32'(starts[k] - starts[k-1]),
                   32'd2);
    end

    // Master moves paddr/pwdata during ACCESS; setup values must win.
    apply_stimulus(0, 1'b1, 32'h1000_0010, 32'hCAFE_0010, 32'h0, 1'b0, 1'b1, 17);
    apply_stimulus(0, 1'b0, 32'h1000_0014, 32'h0, 32'h0, 1'b0, 1'b0, 18);
    apply_stimulus(0, 1'b0, 32'h1000_0010, 32'h0, 32'hCAFE_0010, 1'b0, 1'b1, 19);
    idle(0, 2);

    // Wait-state instance.
    apply_stimulus(3, 1'b0, 32'h1000_0000, 32'h0, 32'h0, 1'b0, 1'b0, 20);
    apply_stimulus(3, 1'b1, 32'h1000_0014, 32'h5555_AAAA, 32'h0, 1'b0, 1'b0, 21);
    apply_stimulus(3, 1'b0, 32'h1000_0014, 32'h0, 32'h5555_AAAA, 1'b0, 1'b0, 22);

    // Reset in the wait phase of a write to REG2.
    drive(3, 1'b1, 1'b0, 1'b1, 32'h1000_0008, 32'h2222_2222);
    @(posedge clk); #1;
    drive(3, 1'b1, 1'b1, 1'b1, 32'h1000_0008, 32'h2222_2222);
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    check_output("mid reset pready", {31'b0, bus3.pready}, 32'd0);
    check_output("mid reset pslverr", {31'b0, bus3.pslverr}, 32'd0);
    check_output("mid reset prdata", bus3.prdata, 32'd0);
    repeat (5) begin @(posedge clk); #1; end
    idle(3, 1);
    apply_stimulus(3, 1'b0, 32'h1000_0008, 32'h0, 32'h0, 1'b0, 1'b0, 23);
    apply_stimulus(3, 1'b0, 32'h1000_001C, 32'h0, 32'd1, 1'b0, 1'b0, 24);

    // Master abort while waiting.
    drive(3, 1'b1, 1'b0, 1'b1, 32'h1000_0008, 32'h3333_3333);
    @(posedge clk); #1;
    drive(3, 1'b1, 1'b1, 1'b1, 32'h1000_0008, 32'h3333_3333);
    @(posedge clk); #1;
    idle(3, 6);
    apply_stimulus(3, 1'b0, 32'h1000_0008, 32'h0, 32'h0, 1'b0, 1'b0, 25);
    apply_stimulus(3, 1'b0, 32'h1000_001C, 32'h0, 32'd3, 1'b0, 1'b0, 26);
    apply_stimulus(3, 1'b1, 32'h1000_0006, 32'h1234, 32'h0, 1'b1, 1'b0, 27);
    apply_stimulus(3, 1'b0, 32'h1000_001C, 32'h0, 32'd4, 1'b0, 1'b0, 28);
    idle(3, 3);

    check_output("scoreboard drained", 32'(q0.size() + q3.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
